// File: rtl/rx_buf_pkg.sv
// Shared types for the RX store-and-forward frame buffer.
// A buffer entry is packed as {last, keep, data}.
package rx_buf_pkg;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_FRAME = 2'd1,
        W_DROP  = 2'd2
    } wr_state_t;

    function automatic int entry_width(input int data_width);
        return data_width + data_width / 8 + 1;
    endfunction

endpackage

// File: rtl/rx_buf_sdp_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// Contents are not reset; the controller ignores stale read data.
module rx_buf_sdp_ram #(
    parameter int WIDTH      = 37,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [WIDTH-1:0]      rd_data_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem[rd_addr_i];
        end
    end

endmodule

// File: rtl/rx_frame_commit_ctrl.sv
// Store-and-forward RX controller: speculative write, commit on good CRC, rollback on bad CRC/overflow.
// Optional frame statistics counters are enabled with the RX_FRAME_STATS_EN macro.
module rx_frame_commit_ctrl
    import rx_buf_pkg::*;
#(
    parameter int  DATA_WIDTH  = 32,
    parameter int  DEPTH       = 512,
    localparam int DATA_NBYTES = DATA_WIDTH / 8,
    localparam int ADDR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [DATA_NBYTES-1:0] s_axis_tkeep,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tuser,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [DATA_NBYTES-1:0] m_axis_tkeep,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   o_drop_crc,
    output logic                   o_drop_ovf,
    output logic [ADDR_WIDTH:0]    o_fill_level
`ifdef RX_FRAME_STATS_EN
    ,
    output logic [31:0]            o_cnt_good,
    output logic [31:0]            o_cnt_crc,
    output logic [31:0]            o_cnt_ovf
`endif
);

    localparam int              EW      = entry_width(DATA_WIDTH);
    localparam int              PW      = ADDR_WIDTH + 1;
    localparam logic [PW-1:0]   DEPTH_P = PW'(DEPTH);

    wr_state_t     state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic          drop_crc_q, drop_crc_d;
    logic          drop_ovf_q, drop_ovf_d;
    logic          commit_evt;
    logic          ram_we;
    logic          full;

    assign full = (wr_ptr_q - rd_ptr_q) == DEPTH_P;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        drop_crc_d   = 1'b0;
        drop_ovf_d   = 1'b0;
        commit_evt   = 1'b0;
        ram_we       = 1'b0;
        if (s_axis_tvalid) begin
            if (state_q == W_DROP) begin
                if (s_axis_tlast) begin
                    state_d = W_IDLE;
                end
            end else if (full) begin
                wr_ptr_d   = commit_ptr_q;
                drop_ovf_d = 1'b1;
                state_d    = s_axis_tlast ? W_IDLE : W_DROP;
            end else begin
                ram_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
                state_d  = W_FRAME;
                if (s_axis_tlast) begin
                    state_d = W_IDLE;
                    if (s_axis_tuser) begin
                        commit_ptr_d = wr_ptr_q + PW'(1);
                        commit_evt   = 1'b1;
                    end else begin
                        wr_ptr_d   = commit_ptr_q;
                        drop_crc_d = 1'b1;
                    end
                end
            end
        end
    end

    // Read side: RAM read in flight plus a 2-entry prefetch that drives m_axis.
    logic [PW-1:0] avail;
    logic          rd_en, pop, inflight_q;
    logic [1:0]    pf_count_q;
    logic          pf_wr_idx_q, pf_rd_idx_q;
    logic [EW-1:0] pf_q [2];
    logic [EW-1:0] ram_rd_data;
    logic [EW-1:0] head;

    assign avail = commit_ptr_q - rd_ptr_q;
    assign pop   = (pf_count_q != 2'd0) && m_axis_tready;
    // A read in flight already owns a prefetch slot, so the prefetch can never overflow.
    assign rd_en = (avail != '0)
                && (({1'b0, pf_count_q} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= W_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            drop_crc_q   <= 1'b0;
            drop_ovf_q   <= 1'b0;
            inflight_q   <= 1'b0;
            pf_count_q   <= 2'd0;
            pf_wr_idx_q  <= 1'b0;
            pf_rd_idx_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                pf_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            drop_crc_q   <= drop_crc_d;
            drop_ovf_q   <= drop_ovf_d;
            inflight_q   <= rd_en;
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (inflight_q) begin
                pf_q[pf_wr_idx_q] <= ram_rd_data;
                pf_wr_idx_q       <= ~pf_wr_idx_q;
            end
            if (pop) begin
                pf_rd_idx_q <= ~pf_rd_idx_q;
            end
            pf_count_q <= pf_count_q + {1'b0, inflight_q} - {1'b0, pop};
        end
    end

    rx_buf_sdp_ram #(
        .WIDTH      (EW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk       (i_clk),
        .wr_en_i   (ram_we),
        .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data_i ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data_o (ram_rd_data)
    );

    assign head          = pf_q[pf_rd_idx_q];
    assign m_axis_tvalid = pf_count_q != 2'd0;
    assign m_axis_tdata  = head[DATA_WIDTH-1:0];
    assign m_axis_tkeep  = head[DATA_WIDTH +: DATA_NBYTES];
    assign m_axis_tlast  = head[EW-1];
    assign o_drop_crc    = drop_crc_q;
    assign o_drop_ovf    = drop_ovf_q;
    assign o_fill_level  = wr_ptr_q - rd_ptr_q;

`ifdef RX_FRAME_STATS_EN
    logic [31:0] cnt_good_q, cnt_crc_q, cnt_ovf_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_good_q <= '0;
            cnt_crc_q  <= '0;
            cnt_ovf_q  <= '0;
        end else begin
            if (commit_evt && (cnt_good_q != 32'hFFFF_FFFF)) cnt_good_q <= cnt_good_q + 32'd1;
            if (drop_crc_d && (cnt_crc_q != 32'hFFFF_FFFF))  cnt_crc_q  <= cnt_crc_q + 32'd1;
            if (drop_ovf_d && (cnt_ovf_q != 32'hFFFF_FFFF))  cnt_ovf_q  <= cnt_ovf_q + 32'd1;
        end
    end

    assign o_cnt_good = cnt_good_q;
    assign o_cnt_crc  = cnt_crc_q;
    assign o_cnt_ovf  = cnt_ovf_q;
`else
    logic unused_commit_evt;
    assign unused_commit_evt = commit_evt;
`endif

endmodule
